// File: rtl/udp_encoder.sv
// Purpose: buffers one UDP payload, computes the RFC 768 checksum and streams header + payload words.
// Latency: ip_start two cycles after the last payload word is accepted; header word follows one cycle later.
// Backpressure: in_ready is high only while loading; the emitted stream is contiguous and cannot be stalled.
module udp_encoder #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dest_port,
  input  logic [15:0] data_len,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] len_out,
  output logic [15:0] checksum,
  output logic        ip_start,
  output logic [31:0] data_out,
  output logic        data_av,
  output logic        fin,
  output logic        err
);

  localparam int          CW        = ADDR_W + 1;
  localparam logic [16:0] MAX_BYTES = 17'(MAX_WORDS * 4);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUM, S_START, S_EMIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]   src_ip_q, dest_ip_q;
  logic [15:0]   src_port_q, dest_port_q, data_len_q;
  logic [CW-1:0] n_q, cnt_q;
  logic [15:0]   sum_q, len_out_q, checksum_q;
  logic          fin_q, err_q;
  logic [31:0]   mem [MAX_WORDS];

  logic          oversize, last_word, emit_last;
  logic [CW-1:0] n_calc;
  logic [31:0]   in_mask, in_word, emit_word;
  logic [15:0]   len_w, sum_final, cks_w;

  // One's-complement add with the end-around carry folded straight back in.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  assign oversize  = {1'b0, data_len} > MAX_BYTES;
  assign n_calc    = CW'((17'(data_len) + 17'd3) >> 2);
  assign last_word = (cnt_q == n_q - CW'(1));
  assign emit_last = (cnt_q == n_q + CW'(1));
  assign len_w     = data_len_q + 16'd8;

  assign len_out  = len_out_q;
  assign checksum = checksum_q;
  assign fin      = fin_q;
  assign err      = err_q;

  // Payload masking, final checksum fold and the emit word selection.
  always_comb begin
    in_mask = 32'hFFFF_FFFF;
    if (last_word) begin
      case (data_len_q[1:0])
        2'd1:    in_mask = 32'hFF00_0000;
        2'd2:    in_mask = 32'hFFFF_0000;
        2'd3:    in_mask = 32'hFFFF_FF00;
        default: in_mask = 32'hFFFF_FFFF;
      endcase
    end
    in_word = in_data & in_mask;

    // Pseudo-header, UDP header (checksum field as zero) on top of the payload sum.
    sum_final = sum_q;
    sum_final = oc_add(sum_final, src_ip_q[31:16]);
    sum_final = oc_add(sum_final, src_ip_q[15:0]);
    sum_final = oc_add(sum_final, dest_ip_q[31:16]);
    sum_final = oc_add(sum_final, dest_ip_q[15:0]);
    sum_final = oc_add(sum_final, 16'h0011);
    sum_final = oc_add(sum_final, len_w);
    sum_final = oc_add(sum_final, src_port_q);
    sum_final = oc_add(sum_final, dest_port_q);
    sum_final = oc_add(sum_final, len_w);
    cks_w = ~sum_final;
    if (cks_w == 16'h0000) cks_w = 16'hFFFF;

    if (cnt_q == CW'(0))      emit_word = {src_port_q, dest_port_q};
    else if (cnt_q == CW'(1)) emit_word = {len_out_q, checksum_q};
    else                      emit_word = mem[ADDR_W'(cnt_q - CW'(2))];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    ip_start = 1'b0;
    data_av  = 1'b0;
    data_out = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (start && !oversize) state_d = (data_len == 16'd0) ? S_SUM : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_d = S_SUM;
      end
      S_SUM:   state_d = S_START;
      S_START: begin
        ip_start = 1'b1;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        data_av  = 1'b1;
        data_out = emit_word;
        if (emit_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Segment fields, word counter, running payload sum and the held status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ip_q    <= 32'h0;
      dest_ip_q   <= 32'h0;
      src_port_q  <= 16'h0;
      dest_port_q <= 16'h0;
      data_len_q  <= 16'h0;
      n_q         <= '0;
      cnt_q       <= '0;
      sum_q       <= 16'h0;
      len_out_q   <= 16'h0;
      checksum_q  <= 16'h0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_ip_q    <= src_ip;
            dest_ip_q   <= dest_ip;
            src_port_q  <= src_port;
            dest_port_q <= dest_port;
            data_len_q  <= data_len;
            n_q         <= n_calc;
            cnt_q       <= '0;
            sum_q       <= 16'h0;
            fin_q       <= 1'b0;
            err_q       <= oversize;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            sum_q <= oc_add(oc_add(sum_q, in_word[31:16]), in_word[15:0]);
            cnt_q <= last_word ? '0 : cnt_q + CW'(1);
          end
        end
        S_SUM: begin
          len_out_q  <= len_w;
          checksum_q <= cks_w;
          cnt_q      <= '0;
        end
        S_EMIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (emit_last) fin_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Payload buffer write; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && in_valid) mem[ADDR_W'(cnt_q)] <= in_word;
  end

endmodule
